// File: rtl/ht_rx_pkg.sv
// Shared types and constants for the hattrick bit-serial receive core.
package ht_rx_pkg;

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_e;

  // Descrambler polynomial 1+x^14+x^15: taps index the line history.
  localparam int TAP_A    = 13;
  localparam int TAP_B    = 14;
  localparam int HIST_LEN = 15;

  localparam logic [15:0] SYNC_DEFAULT = 16'hF628;

  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ht_descrambler.sv
// Self-synchronising descrambler (1+x^14+x^15). Only compiled when
// HT_RX_DESCRAMBLER_EN is defined.
`ifdef HT_RX_DESCRAMBLER_EN
module ht_descrambler
  import ht_rx_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                A,
  output logic                d,
  output logic [HIST_LEN-1:0] hist
);

  assign d = A ^ hist[TAP_A] ^ hist[TAP_B];

  always_ff @(posedge clock or negedge reset)
    if (!reset) hist <= '0;
    else        hist <= {hist[HIST_LEN-2:0], A};

endmodule
`endif

// File: rtl/ht_rx_core.sv
// Bit-serial receive core: optional descrambler (HT_RX_DESCRAMBLER_EN),
// sync-word hunt, then one FRAME_LEN-bit payload passed to Z.
module ht_rx_core
  import ht_rx_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = SYNC_DEFAULT,
  parameter int          FRAME_LEN = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic A,
  output logic Z
);

  localparam int            CW   = cnt_w(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  logic d;

`ifdef HT_RX_DESCRAMBLER_EN
  logic [HIST_LEN-1:0] hist;
  logic                unused_hist;

  ht_descrambler u_dscr (
    .clock (clock),
    .reset (reset),
    .A     (A),
    .d     (d),
    .hist  (hist)
  );
  // History is exported for debug visibility only.
  assign unused_hist = ^hist;
`else
  assign d = A;
`endif

  state_e        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [14:0]   sreg;
  logic [15:0]   win;
  logic          z_n;

  assign win = {sreg, d};

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= HUNT;
      cnt   <= '0;
      sreg  <= '0;
      Z     <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sreg  <= win[14:0];
      Z     <= z_n;
    end

  // Sync is not searched in LOCK, so an in-payload sync pattern is data.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    z_n     = 1'b0;
    case (state)
      HUNT:
        if (win == SYNC_WORD) begin
          state_n = LOCK;
          cnt_n   = '0;
        end
      LOCK: begin
        z_n = d;
        if (cnt == LAST) begin
          state_n = HUNT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = HUNT;
    endcase
  end

endmodule

// File: tb/tb_ht_rx_core.sv
// Bench for ht_rx_core: a 64-bit-frame and a 4-bit-frame instance share
// one line; a queue-based reference model predicts Z for both.
module tb_ht_rx_core;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic A     = 1'b0;
  logic Z64, Z4;

  int checks = 0;
  int errors = 0;

  ht_rx_core #(.SYNC_WORD(16'hF628), .FRAME_LEN(64)) u64 (
    .clock(clock), .reset(reset), .A(A), .Z(Z64));
  ht_rx_core #(.SYNC_WORD(16'hF628), .FRAME_LEN(4)) u4 (
    .clock(clock), .reset(reset), .A(A), .Z(Z4));

  always #5 clock = ~clock;

  // Reference model: full line history and descrambled history since reset.
  bit          aq[$];
  bit          dq[$];
  int          rem64, rem4;
  logic        e64, e4;
  logic [14:0] eh;          // encoder (transmit scrambler) state
  logic [63:0] zh64, zh4;   // recent Z samples, newest in bit 0

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic frame_model(inout int rem, input int flen, input bit d,
                             input logic [15:0] w, output logic e);
    if (rem > 0) begin
      e = d;
      rem--;
    end else begin
      e = 1'b0;
      if (w == 16'hF628) rem = flen;
    end
  endtask

  task automatic model_step(input bit a);
    int n;
    bit d;
    logic [15:0] w;
    aq.push_back(a);
    n = aq.size() - 1;
`ifdef HT_RX_DESCRAMBLER_EN
    d = a ^ ((n >= 14) ? aq[n-14] : 1'b0) ^ ((n >= 15) ? aq[n-15] : 1'b0);
`else
    d = a;
`endif
    dq.push_back(d);
    w = '0;
    for (int i = 0; i < 16; i++) begin
      int idx;
      idx = dq.size() - 16 + i;
      w = {w[14:0], (idx >= 0) ? dq[idx] : 1'b0};
    end
    frame_model(rem64, 64, d, w, e64);
    frame_model(rem4, 4, d, w, e4);
  endtask

  // Drive one line bit, clock it, then compare both outputs to the model.
  task automatic tick(input bit a);
    A = a;
    @(posedge clock);
    model_step(a);
    #1;
    zh64 = {zh64[62:0], Z64};
    zh4  = {zh4[62:0], Z4};
    check("z64", {63'd0, Z64}, {63'd0, e64});
    check("z4",  {63'd0, Z4},  {63'd0, e4});
  endtask

  // Transmit one data bit through the line scrambler.
  task automatic send(input bit dbit);
    bit l;
`ifdef HT_RX_DESCRAMBLER_EN
    l  = dbit ^ eh[13] ^ eh[14];
    eh = {eh[13:0], l};
`else
    l = dbit;
`endif
    tick(l);
  endtask

  task automatic send_word(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send(v[i]);
  endtask

  task automatic do_reset(input logic [14:0] pre);
    @(negedge clock);
    reset = 1'b0;
    A     = 1'b0;
    aq.delete();
    dq.delete();
    rem64 = 0;
    rem4  = 0;
    eh    = pre;
    zh64  = '0;
    zh4   = '0;
    @(negedge clock);
    check("rst_z64", {63'd0, Z64}, 64'd0);
    check("rst_z4",  {63'd0, Z4},  64'd0);
    reset = 1'b1;
  endtask

  initial begin
    logic [63:0] pay;
    logic [14:0] pre;

    // Reset held with the line toggling: outputs stay low.
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      A = ~A;
      check("hold_rst_z64", {63'd0, Z64}, 64'd0);
      check("hold_rst_z4",  {63'd0, Z4},  64'd0);
    end

    // Sync then alternating payload.
    do_reset('0);
    send_word(64'hF628, 16);
    send_word(64'hAAAA_AAAA_AAAA_AAAA, 64);
    check("alt_payload", zh64, 64'hAAAA_AAAA_AAAA_AAAA);
    send(1'b1);
    check("alt_after", {63'd0, Z64}, 64'd0);

    // Wrong sync: never locks.
    do_reset('0);
    send_word(64'hF629, 16);
    send_word('1, 64);
    check("badsync_z64", zh64, 64'd0);

    // All-ones payload from a zero encoder state.
    do_reset('0);
    send_word(64'hF628, 16);
    send_word('1, 64);
    check("ones_zero_pre", zh64, '1);

    // Random encoder preload, 15 junk bits to train the descrambler.
    pre = 15'($urandom);
    do_reset(pre);
    for (int i = 0; i < 15; i++) send(1'($urandom));
    send_word(64'hF628, 16);
    send_word('1, 64);
    check("ones_rand_pre", zh64, '1);

    // Random payloads, several frames.
    for (int k = 0; k < 4; k++) begin
      do_reset('0);
      pay = {$urandom, $urandom};
      send_word(64'hF628, 16);
      send_word(pay, 64);
      check("rand_payload", zh64, pay);
      send(1'($urandom));
    end

    // Back-to-back 4-bit frames.
    do_reset('0);
    send_word(64'hF628, 16);
    send_word(64'hB, 4);
    send_word(64'hF628, 16);
    send_word(64'h6, 4);
    check("b2b_z4", {24'd0, zh4[39:0]}, 64'h00_000B_0000_6);
    send(1'b0);
    check("b2b_after", {63'd0, Z4}, 64'd0);

    // Sync pattern embedded in the payload passes through as data.
    do_reset('0);
    pay = 64'h1234_F628_5678_9ABC;
    send_word(64'hF628, 16);
    send_word(pay, 64);
    check("embed_payload", zh64, pay);
    send(1'b1);
    check("embed_end", {63'd0, Z64}, 64'd0);

    // Asynchronous reset mid-frame: Z drops without a clock edge.
    do_reset('0);
    send_word(64'hF628, 16);
    send_word('1, 20);
    check("mid_frame_z64", {63'd0, Z64}, 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_z64", {63'd0, Z64}, 64'd0);
    check("async_rst_z4",  {63'd0, Z4},  64'd0);
    do_reset('0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
